sdm_tx: RTL and testbench
=========================

SDM_TX -- requirements
Module: sdm_tx

Interface
REQ-001 Parameter: DECIM, default 256, modulator bits emitted per PCM sample (power of two, 16..1024).
REQ-002 Parameter: FS, default 32768, feedback magnitude representing full scale.
REQ-003 Port: Clock  input  1  single clock for all state; rising edge.
REQ-004 Port: Reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: En  input  1  run enable; low requests return to IDLE at the next period boundary.
REQ-006 Port: Din  input  16  signed two's-complement PCM sample.
REQ-007 Port: Push  input  1  Din valid this cycle.
REQ-008 Port: Stall  output  1  sample buffer full; a Push while high is dropped.
REQ-009 Port: BitOut  output  1  modulated bitstream; 1 = +FS, 0 = -FS.
REQ-010 Port: FILTER  output  1  one-cycle strobe on the last bit of each DECIM-bit period (frame marker for downstream decimator).
REQ-011 Port: Underrun  output  1  sticky; a period started with an empty buffer.
REQ-012 Port: Overflow  output  1  sticky; a Push arrived while Stall was high.

Function
REQ-013 Buffer: 2-entry FIFO; Stall = registered count == 2; Push with Stall low writes Din at the clock edge.
REQ-014 Simultaneous pop and Push at count 2: Stall is high, so the Push is dropped and Overflow sets; pop still occurs.
REQ-015 States: IDLE, PRIME, RUN.
REQ-016 IDLE: integrators held at 0, FILTER 0, BitOut toggles every cycle (zero-mean idle pattern); En=1 -> PRIME.
REQ-017 PRIME: when FIFO non-empty, pop into hold register, phase counter <= 0, -> RUN; En=0 -> IDLE.
REQ-018 RUN: each cycle, with x = hold sign-extended and fb = BitOut ? +FS : -FS: int1 <= sat20(int1 + x - fb); int2 <= sat24(int2 + int1_next - fb); BitOut <= (int2_next >= 0).
REQ-019 Integrators signed, int1 20 bits, int2 24 bits; saturate at their limits, never wrap.
REQ-020 Phase counter increments each RUN cycle, wraps DECIM-1 -> 0; FILTER = 1 exactly in the cycle phase == DECIM-1.
REQ-021 At phase == DECIM-1: if FIFO non-empty, pop into hold; else keep hold and set Underrun.
REQ-022 At phase == DECIM-1 with En=0: -> IDLE, integrators cleared; FIFO contents retained.
REQ-023 Latency: first BitOut of a sample appears the cycle after the RUN entry edge; each sample drives exactly DECIM bits.
REQ-024 Underrun/Overflow clear only on reset.

Reset
REQ-025 Reset_n low asynchronously forces: state IDLE, FIFO empty, hold 0, int1/int2 0, phase 0, BitOut 0, FILTER 0, Stall 0, Underrun 0, Overflow 0.
REQ-026 Reset mid-RUN aborts the period immediately; no FILTER strobe is emitted for it.
REQ-027 Outputs are register-driven; no combinational path from inputs to outputs.

Structure
REQ-028 Package sdm_pkg holds state_t enum (IDLE, PRIME, RUN), integrator width constants (20, 24), DECIM and FS defaults.
REQ-029 The FIFO is one sub-module, sample_fifo2 (2-entry, count output, push/pop, async active-low reset); all else in sdm_tx.

Verification
REQ-030 Reset, En=1, keep FIFO fed with Din=0 -> every 256-bit period contains 128 +/-1 ones; FILTER every 256 cycles.
REQ-031 Din=+16384 constant -> 192 +/-2 ones per period after the first two periods.
REQ-032 Din=-32768 constant -> at most 2 ones per period; int1/int2 never wrap sign (probe saturation).
REQ-033 In IDLE push 3 samples on consecutive cycles -> Stall high after 2nd, 3rd dropped, Overflow=1, first two samples played in order.
REQ-034 Single Push then none -> at end of first period Underrun=1, second period repeats same sample (same ones count +/-2).
REQ-035 Reset_n low at phase 100 of RUN -> all outputs 0 in the same cycle, no FILTER; after release state IDLE, BitOut toggling.

Source files
------------

// File: rtl/sdm_pkg.sv
// Shared types and constants for the second-order sigma-delta transmitter.
package sdm_pkg;

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   localparam int INT1_W    = 20;
   localparam int INT2_W    = 24;
   localparam int DECIM_DEF = 256;
   localparam int FS_DEF    = 32768;

   // Clip a 32-bit signed value into the range of a w-bit signed integer.
   function automatic logic signed [31:0] sat_w(input logic signed [31:0] v, input int w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/sample_fifo2.sv
// Two-entry sample buffer with occupancy count; writes to a full buffer are ignored.
module sample_fifo2 #(
   parameter int W = 16
) (
   input  logic         Clock,
   input  logic         Reset_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   count
);

   logic       wr_ptr_reg;
   logic       rd_ptr_reg;
   logic [1:0] count_reg;
   logic       push_ok;
   logic       pop_ok;

   assign push_ok = push && (count_reg != 2'd2);
   assign pop_ok  = pop && (count_reg != 2'd0);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_entry
         logic [W-1:0] data_reg;
         always_ff @(posedge Clock or negedge Reset_n) begin
            if (!Reset_n)
               data_reg <= '0;
            else if (push_ok && (wr_ptr_reg == 1'(gi)))
               data_reg <= din;
         end
      end
   endgenerate

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
         if (pop_ok)  rd_ptr_reg <= ~rd_ptr_reg;
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign dout  = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;
   assign count = count_reg;

endmodule

// File: rtl/sdm_tx.sv
// Second-order 1-bit sigma-delta modulator: each buffered PCM sample drives DECIM output bits.
module sdm_tx
   import sdm_pkg::*;
#(
   parameter int DECIM = DECIM_DEF,
   parameter int FS    = FS_DEF
) (
   input  logic               Clock,
   input  logic               Reset_n,
   input  logic               En,
   input  logic signed [15:0] Din,
   input  logic               Push,
   output logic               Stall,
   output logic               BitOut,
   output logic               FILTER,
   output logic               Underrun,
   output logic               Overflow
);

   localparam int                 PW      = $clog2(DECIM);
   localparam logic [PW-1:0]      PH_LAST = PW'(DECIM - 1);
   localparam logic [PW-1:0]      PH_PRE  = PW'(DECIM - 2);
   localparam logic signed [31:0] FB_POS  = 32'(FS);
   localparam logic signed [31:0] FB_NEG  = 32'(-FS);

   state_t                    state_reg, state_next;
   logic [PW-1:0]             phase_reg, phase_next;
   logic signed [15:0]        hold_reg, hold_next;
   logic signed [INT1_W-1:0]  int1_reg, int1_next;
   logic signed [INT2_W-1:0]  int2_reg, int2_next;
   logic                      bit_reg, bit_next;
   logic                      filter_reg, filter_next;
   logic                      underrun_reg, underrun_next;
   logic                      overflow_reg, overflow_next;

   logic                      fifo_pop;
   logic [15:0]               fifo_dout;
   logic [1:0]                fifo_count;
   logic                      fifo_full;

   logic signed [31:0]        x_ext, fb, int1_s, int2_s;

   sample_fifo2 #(.W(16)) u_fifo (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .push    (Push),
      .pop     (fifo_pop),
      .din     (Din),
      .dout    (fifo_dout),
      .count   (fifo_count)
   );

   assign fifo_full = (fifo_count == 2'd2);

   // Loop arithmetic is done at 32 bits so the sums cannot wrap before clipping.
   assign x_ext  = 32'(hold_reg);
   assign fb     = bit_reg ? FB_POS : FB_NEG;
   assign int1_s = sat_w(32'(int1_reg) + x_ext - fb, INT1_W);
   assign int2_s = sat_w(32'(int2_reg) + int1_s - fb, INT2_W);

   always_comb begin
      state_next    = state_reg;
      phase_next    = phase_reg;
      hold_next     = hold_reg;
      int1_next     = int1_reg;
      int2_next     = int2_reg;
      bit_next      = bit_reg;
      filter_next   = 1'b0;
      underrun_next = underrun_reg;
      overflow_next = overflow_reg | (Push & fifo_full);
      fifo_pop      = 1'b0;

      case (state_reg)
         IDLE: begin
            int1_next = '0;
            int2_next = '0;
            bit_next  = ~bit_reg;
            if (En) state_next = PRIME;
         end
         PRIME: begin
            if (!En) begin
               state_next = IDLE;
            end else if (fifo_count != 2'd0) begin
               fifo_pop   = 1'b1;
               hold_next  = fifo_dout;
               phase_next = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            int1_next   = int1_s[INT1_W-1:0];
            int2_next   = int2_s[INT2_W-1:0];
            bit_next    = (int2_s >= 0);
            phase_next  = phase_reg + 1'b1;
            filter_next = (phase_reg == PH_PRE);
            if (phase_reg == PH_LAST) begin
               if (!En) begin
                  // Buffered samples stay queued for the next run.
                  state_next = IDLE;
                  int1_next  = '0;
                  int2_next  = '0;
               end else if (fifo_count != 2'd0) begin
                  fifo_pop  = 1'b1;
                  hold_next = fifo_dout;
               end else begin
                  underrun_next = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg    <= IDLE;
         phase_reg    <= '0;
         hold_reg     <= '0;
         int1_reg     <= '0;
         int2_reg     <= '0;
         bit_reg      <= 1'b0;
         filter_reg   <= 1'b0;
         underrun_reg <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         phase_reg    <= phase_next;
         hold_reg     <= hold_next;
         int1_reg     <= int1_next;
         int2_reg     <= int2_next;
         bit_reg      <= bit_next;
         filter_reg   <= filter_next;
         underrun_reg <= underrun_next;
         overflow_reg <= overflow_next;
      end
   end

   assign Stall    = fifo_full;
   assign BitOut   = bit_reg;
   assign FILTER   = filter_reg;
   assign Underrun = underrun_reg;
   assign Overflow = overflow_reg;

endmodule

// File: tb/tb_sdm_tx.sv
// Self-checking bench for sdm_tx: per-period ones counts scored against a sample queue.
module tb_sdm_tx;

   localparam int DECIM = 256;
   localparam int FS    = 32768;

   logic               Clock   = 1'b0;
   logic               Reset_n = 1'b0;
   logic               En      = 1'b0;
   logic               Push    = 1'b0;
   logic signed [15:0] Din     = '0;
   logic               Stall, BitOut, FILTER, Underrun, Overflow;

   always #5 Clock = ~Clock;

   sdm_tx #(.DECIM(DECIM), .FS(FS)) dut (
      .Clock    (Clock),
      .Reset_n  (Reset_n),
      .En       (En),
      .Din      (Din),
      .Push     (Push),
      .Stall    (Stall),
      .BitOut   (BitOut),
      .FILTER   (FILTER),
      .Underrun (Underrun),
      .Overflow (Overflow)
   );

   typedef struct { int lo; int hi; bit chk; string tag; } exp_t;
   typedef struct { string tag; logic signed [15:0] din; int lo; int hi; int warm; int nper; bit probe; } vec_t;

   exp_t sb_q[$];
   exp_t last_e;
   vec_t vecs[5];
   bit   have_last, pending, gap_valid, counting;
   int   errors, checks, acc, prev_ones, periods_done, gap, filter_total;

   task automatic chk(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
      end else begin
         $display("ok   %s: got %0d, want %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic finalize_period();
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         last_e = e;
         have_last = 1'b1;
         if (e.chk) chk({"ones_", e.tag}, acc, e.lo, e.hi);
      end else if (have_last) begin
         // Buffer ran dry: the held sample must be replayed.
         chk({"repeat_range_", last_e.tag}, acc, last_e.lo, last_e.hi);
         chk({"repeat_same_", last_e.tag}, acc, prev_ones - 2, prev_ones + 2);
      end
      prev_ones = acc;
      acc = 0;
      pending = 1'b0;
      periods_done++;
   endtask

   task automatic monitor();
      forever begin
         @(negedge Clock);
         if (!Reset_n) begin
            acc = 0; pending = 1'b0; gap = 0; gap_valid = 1'b0;
            periods_done = 0; have_last = 1'b0;
         end else begin
            gap++;
            if (FILTER) begin
               filter_total++;
               if (gap_valid) chk("filter_gap", gap, DECIM, DECIM);
               gap_valid = 1'b1;
               gap = 0;
            end
            if (counting) begin
               acc += int'(BitOut);
               if (pending) finalize_period();
               if (FILTER) pending = 1'b1;
            end
         end
      end
   endtask

   task automatic do_reset();
      Reset_n = 1'b0; En = 1'b0; Push = 1'b0; Din = '0; counting = 1'b0;
      sb_q.delete();
      repeat (3) @(negedge Clock);
      Reset_n = 1'b1;
   endtask

   task automatic push_rec(input logic signed [15:0] d, input int lo, input int hi,
                           input bit c, input string tag);
      exp_t e;
      Din = d;
      Push = 1'b1;
      e.lo = lo; e.hi = hi; e.chk = c; e.tag = tag;
      sb_q.push_back(e);
   endtask

   task automatic idle_toggle(input string tag);
      logic prev;
      prev = BitOut;
      repeat (4) begin
         @(negedge Clock);
         chk(tag, int'(BitOut), int'(!prev), int'(!prev));
         prev = BitOut;
      end
   endtask

   task automatic wait_periods(input int n, input string tag);
      int c;
      c = 0;
      while (periods_done < n && c < (n + 2) * DECIM) begin
         @(negedge Clock);
         c++;
      end
      chk({"periods_", tag}, periods_done, n, n);
   endtask

   task automatic start_run();
      En = 1'b1;
      repeat (3) @(posedge Clock);
      counting = 1'b1;
   endtask

   initial begin
      int k, cyc, fsnap;
      errors = 0; checks = 0; filter_total = 0; counting = 1'b0;
      fork
         monitor();
      join_none

      // Reset state
      repeat (2) @(negedge Clock);
      chk("rst_stall", int'(Stall), 0, 0);
      chk("rst_bitout", int'(BitOut), 0, 0);
      chk("rst_filter", int'(FILTER), 0, 0);
      chk("rst_underrun", int'(Underrun), 0, 0);
      chk("rst_overflow", int'(Overflow), 0, 0);
      Reset_n = 1'b1;
      @(negedge Clock);
      idle_toggle("idle_toggle_after_reset");

      // Constant-input table: ones per period = DECIM*(x+FS)/(2*FS)
      vecs[0] = '{"zero",   16'sd0,      127, 129, 1, 4, 1'b0};
      vecs[1] = '{"p16384", 16'sd16384,  190, 194, 2, 5, 1'b0};
      vecs[2] = '{"m32768", 16'sh8000,   0,   2,   0, 4, 1'b1};
      vecs[3] = '{"m16384", -16'sd16384, 62,  66,  2, 5, 1'b0};
      vecs[4] = '{"p8192",  16'sd8192,   158, 162, 2, 4, 1'b0};

      for (int i = 0; i < 5; i++) begin
         do_reset();
         k = 0;
         repeat (2) begin
            @(negedge Clock);
            push_rec(vecs[i].din, vecs[i].lo, vecs[i].hi, k >= vecs[i].warm, vecs[i].tag);
            k++;
         end
         @(negedge Clock);
         Push = 1'b0;
         start_run();
         cyc = 0;
         while (periods_done < vecs[i].nper && cyc < (vecs[i].nper + 1) * DECIM) begin
            @(negedge Clock);
            if (!Stall) begin
               push_rec(vecs[i].din, vecs[i].lo, vecs[i].hi, k >= vecs[i].warm, vecs[i].tag);
               k++;
            end else begin
               Push = 1'b0;
            end
            cyc++;
         end
         Push = 1'b0;
         counting = 1'b0;
         chk({"periods_", vecs[i].tag}, periods_done, vecs[i].nper, vecs[i].nper);
         chk({"no_underrun_", vecs[i].tag}, int'(Underrun), 0, 0);
         chk({"no_overflow_", vecs[i].tag}, int'(Overflow), 0, 0);
         if (vecs[i].probe) chk({"int2_saturated_", vecs[i].tag}, int'(dut.int2_reg), -8388608, -8388608);
      end

      // Three back-to-back pushes while idle: third is dropped
      do_reset();
      @(negedge Clock);
      push_rec(-16'sd16384, 61, 67, 1'b1, "ov_s1");
      @(negedge Clock);
      chk("stall_after_1st", int'(Stall), 0, 0);
      push_rec(16'sd16384, 189, 195, 1'b1, "ov_s2");
      @(negedge Clock);
      chk("stall_after_2nd", int'(Stall), 1, 1);
      Din = 16'sd0;
      Push = 1'b1;
      @(negedge Clock);
      Push = 1'b0;
      chk("overflow_set", int'(Overflow), 1, 1);
      chk("stall_hold", int'(Stall), 1, 1);
      start_run();
      wait_periods(3, "ov");
      counting = 1'b0;
      chk("ov_underrun", int'(Underrun), 1, 1);
      chk("ov_sticky", int'(Overflow), 1, 1);

      // Single sample then starvation, then En low returns to idle at the boundary
      do_reset();
      @(negedge Clock);
      push_rec(16'sd8192, 157, 163, 1'b1, "u_single");
      @(negedge Clock);
      Push = 1'b0;
      start_run();
      @(negedge Clock);
      chk("underrun_before", int'(Underrun), 0, 0);
      wait_periods(2, "u");
      counting = 1'b0;
      chk("underrun_set", int'(Underrun), 1, 1);
      En = 1'b0;
      fsnap = filter_total;
      cyc = 0;
      while (filter_total == fsnap && cyc < DECIM + 10) begin
         @(negedge Clock);
         cyc++;
      end
      chk("final_filter_seen", filter_total - fsnap, 1, 1);
      repeat (2) @(negedge Clock);
      idle_toggle("idle_toggle_after_stop");
      fsnap = filter_total;
      repeat (DECIM + 20) @(negedge Clock);
      chk("idle_no_filter", filter_total - fsnap, 0, 0);
      chk("underrun_sticky", int'(Underrun), 1, 1);

      // Asynchronous reset at phase 100 of a period
      do_reset();
      repeat (2) begin
         @(negedge Clock);
         Din = 16'sd0;
         Push = 1'b1;
      end
      @(negedge Clock);
      Push = 1'b0;
      En = 1'b1;
      repeat (2) @(posedge Clock);
      repeat (100) @(posedge Clock);
      #2 Reset_n = 1'b0;
      #1;
      chk("abort_bitout", int'(BitOut), 0, 0);
      chk("abort_filter", int'(FILTER), 0, 0);
      chk("abort_stall", int'(Stall), 0, 0);
      chk("abort_underrun", int'(Underrun), 0, 0);
      chk("abort_overflow", int'(Overflow), 0, 0);
      chk("abort_phase", int'(dut.phase_reg), 0, 0);
      En = 1'b0;
      fsnap = filter_total;
      repeat (4) @(negedge Clock);
      Reset_n = 1'b1;
      repeat (DECIM + 20) @(negedge Clock);
      chk("abort_no_filter", filter_total - fsnap, 0, 0);
      idle_toggle("idle_toggle_after_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
